instr_mem_loader: RTL and testbench

Sequential instruction encoder and loader: the writer side of the opcode-decode path in the single-cycle MIPS core. It accepts instruction fields (format, opcode, registers, immediate, target) over a valid/ready handshake, packs them into 32-bit MIPS R/I/J words, and writes them one per transaction into the program/instruction memory at consecutive word addresses. It is used to preload programs before the core leaves reset and as the stimulus generator for decoder/control testbenches.

---
 rtl/instr_mem_loader.sv | 153 +++++++++++++++
 tb/tb_instr_mem_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: packs MIPS R/I/J instruction fields into 32-bit words
// and writes them, one per accepted bundle, into instruction memory at
// consecutive word addresses starting at BASE_ADDR.
//
// Handshake: a bundle is accepted on a rising edge where in_valid and
// in_ready are both high. in_ready depends only on the state and on start,
// never on in_valid. The producer holds the bundle stable until it is accepted.
module instr_mem_loader #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_fmt,
  input  logic [5:0]            in_op,
  input  logic [4:0]            in_rs,
  input  logic [4:0]            in_rt,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_shamt,
  input  logic [5:0]            in_funct,
  input  logic [15:0]           in_imm,
  input  logic [25:0]           in_target,
  input  logic                  in_last,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   count,
  output logic [2:0]            dbg_state
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  localparam logic [1:0] FMT_R = 2'd0;
  localparam logic [1:0] FMT_I = 2'd1;
  localparam logic [1:0] FMT_J = 2'd2;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  last_q, last_d;

  logic                  accept;
  logic [31:0]           word;

  // Encode the presented bundle; R-type forces a zero opcode.
  always_comb begin
    word = 32'h0;
    case (in_fmt)
      FMT_R:   word = {6'h00, in_rs, in_rt, in_rd, in_shamt, in_funct};
      FMT_I:   word = {in_op, in_rs, in_rt, in_imm};
      FMT_J:   word = {in_op, in_target};
      default: word = 32'h0;
    endcase
  end

  assign in_ready = (state_q == ST_LOAD) && !start;
  assign accept   = in_valid && in_ready;

  // Next-state and datapath: a write is staged on accept and retired in WRITE.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    count_d = count_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    last_d  = last_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_LOAD;
          index_d = '0;
          count_d = '0;
        end
      end
      ST_LOAD: begin
        if (start) begin
          // Restart wins over a simultaneous bundle.
          index_d = '0;
          count_d = '0;
        end else if (accept) begin
          if (in_fmt == 2'd3) begin
            state_d = ST_ERR;
          end else begin
            addr_d  = BASE_ADDR + (32'(index_q) << 2);
            wdata_d = word;
            last_d  = in_last;
            we_d    = 1'b1;
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        // The strobe is live this cycle; advance and pick the successor.
        index_d = index_q + 1'b1;
        count_d = count_q + 1'b1;
        if (last_q) begin
          state_d = ST_DONE;
        end else if (index_d == '0) begin
          // All DEPTH words used without a last bundle: overflow.
          state_d = ST_ERR;
        end else begin
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered write port; reset kills any in-flight write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      count_q <= '0;
      addr_q  <= BASE_ADDR;
      wdata_q <= 32'h0;
      we_q    <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      last_q  <= last_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_WRITE);
  assign done      = (state_q == ST_DONE);
  assign error     = (state_q == ST_ERR);
  assign count     = count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader (ADDR_WIDTH 2, so overflow is reachable).
// A transaction-level model predicts writes and status from the handshake
// rules; one negedge process compares every cycle; directed literals pin the model.
module tb_instr_mem_loader;

  localparam int          AW    = 2;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] BASE  = 32'h0040_0000;

  logic          clk, rst, start, in_valid, in_ready, in_last;
  logic [1:0]    in_fmt;
  logic [5:0]    in_op, in_funct;
  logic [4:0]    in_rs, in_rt, in_rd, in_shamt;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          mem_we, busy, done, error;
  logic [31:0]   mem_addr, mem_wdata;
  logic [AW:0]   count;
  logic [2:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  instr_mem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .count(count), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] encode(input logic [1:0] fmt, input logic [5:0] op,
      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
      input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] tg);
    case (fmt)
      2'd0:    return {6'h00, rs, rt, rd, sh, fn};
      2'd1:    return {op, rs, rt, imm};
      default: return {op, tg};
    endcase
  endfunction

  // Model: phase 0 idle, 1 loading, 2 done, 3 error; m_wr = write due this cycle.
  int              m_phase = 0;
  bit              m_wr = 1'b0;
  int              m_count = 0;
  int              m_index = 0;
  bit              prev_we = 1'b0;
  logic [64:0]     exp_q[$];
  logic [64:0]     m_log[$];

  // Compare process: check all outputs against the model, then advance it.
  always @(negedge clk) begin
    logic [64:0] e;
    if (rst) begin
      m_phase = 0; m_wr = 1'b0; m_count = 0; m_index = 0; prev_we = 1'b0;
      exp_q.delete();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, BASE);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_count", count, 0);
    end else begin
      chk("in_ready", in_ready, (m_phase == 1) && !m_wr && !start);
      chk("busy", busy, m_phase == 1);
      chk("done", done, m_phase == 2);
      chk("error", error, m_phase == 3);
      chk("count", count, m_count);
      chk("mem_we", mem_we, m_wr);
      chk("we_back_to_back", mem_we & prev_we, 0);
      prev_we = mem_we;
      if (m_wr) begin
        e = exp_q.pop_front();
        chk("mem_addr", mem_addr, e[63:32]);
        chk("mem_wdata", mem_wdata, e[31:0]);
        m_count++;
        m_index = (m_index + 1) % DEPTH;
        m_wr = 1'b0;
        if (e[64]) m_phase = 2;
        else if (m_index == 0) m_phase = 3;
      end else if (start) begin
        m_phase = 1; m_count = 0; m_index = 0;
      end else if (m_phase == 1 && in_valid) begin
        if (in_fmt == 2'd3) begin
          m_phase = 3;
        end else begin
          e = {in_last, BASE + 32'(m_index) * 32'd4,
               encode(in_fmt, in_op, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target)};
          exp_q.push_back(e);
          m_log.push_back(e);
          m_wr = 1'b1;
        end
      end
    end
  end

  // Driver tasks: every task starts and ends one time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic set_fields(input logic [1:0] fmt, input logic [5:0] op, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
      input logic [15:0] imm, input logic [25:0] tg, input logic last);
    in_fmt = fmt; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_funct = fn; in_imm = imm; in_target = tg; in_last = last;
  endtask

  task automatic send(input logic [1:0] fmt, input logic [5:0] op, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
      input logic [15:0] imm, input logic [25:0] tg, input logic last);
    bit got = 1'b0;
    set_fields(fmt, op, rs, rt, rd, sh, fn, imm, tg, last);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk("accept_within_budget", got, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    set_fields(2'd0, 6'h0, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single I-type word with last.
    pulse_start();
    send(2'd1, 6'h08, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0005, 26'h0, 1'b1);
    idle(2);
    @(negedge clk);
    chk("t1_done", done, 1);
    chk("t1_busy", busy, 0);
    chk("t1_count", count, 1);
    chk("t1_model_word", m_log[0][63:0], {32'h0040_0000, 32'h2008_0005});

    // Three-bundle program R, I, J.
    pulse_start();
    send(2'd0, 6'h3F, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'h0, 26'h0, 1'b0);
    send(2'd1, 6'h0D, 5'd0, 5'd9, 5'd0, 5'd0, 6'h0, 16'h00FF, 26'h0, 1'b0);
    send(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0100000, 1'b1);
    idle(2);
    @(negedge clk);
    chk("t2_done", done, 1);
    chk("t2_count", count, 3);
    chk("t2_model_r", m_log[1][63:0], {32'h0040_0000, 32'h0109_5020});
    chk("t2_model_i", m_log[2][63:0], {32'h0040_0004, 32'h3409_00FF});
    chk("t2_model_j", m_log[3][63:0], {32'h0040_0008, 32'h0810_0000});

    // Overflow: DEPTH words without last, fifth bundle refused.
    pulse_start();
    for (int k = 0; k < DEPTH; k++)
      send(2'd1, 6'h09, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'(k + 16'h100), 26'h0, 1'b0);
    set_fields(2'd1, 6'h09, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'h0AAA, 26'h0, 1'b0);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("ovf_not_ready", in_ready, 0);
    end
    chk("ovf_error", error, 1);
    chk("ovf_count", count, 4);
    chk("ovf_model_last_addr", m_log[7][63:32], 32'h0040_000C);
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Reserved format, then restart clears error and count.
    pulse_start();
    send(2'd3, 6'h3F, 5'd1, 5'd1, 5'd1, 5'd1, 6'h1, 16'h1, 26'h1, 1'b0);
    @(negedge clk);
    chk("rsv_error", error, 1);
    chk("rsv_no_write", mem_we, 0);
    pulse_start();
    @(negedge clk);
    chk("rsv_restart_error", error, 0);
    chk("rsv_restart_count", count, 0);

    // Reset during the write cycle.
    @(posedge clk); #1;
    send(2'd1, 6'h23, 5'd3, 5'd4, 5'd0, 5'd0, 6'h0, 16'h0010, 26'h0, 1'b0);
    chk("wr_in_flight", mem_we, 1);
    rst = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("rst_we_async", mem_we, 0);
    chk("rst_state_idle", dbg_state, 0);
    idle(2);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_not_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Start and valid together in LOAD: start wins, next cycle accepts.
    pulse_start();
    set_fields(2'd1, 6'h08, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'h1234, 26'h0, 1'b1);
    start = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("sv_not_ready", in_ready, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("sv_count_zero", count, 0);
    chk("sv_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("sv_we", mem_we, 1);
    chk("sv_addr", mem_addr, 32'h0040_0000);
    chk("sv_data", mem_wdata, 32'h2001_1234);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
